// File: rtl/fnd_pkg.sv
// Shared types, segment constants and helpers for the multiplexed 7-segment scan controller.
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } conv_state_e;

  // Segment patterns are bits6:0 = g..a, active-low.
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Value handshake between a producer and the scan controller.
interface fnd_scan_controller_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) ();
  logic [VALUE_W-1:0]    i_value;
  logic [NUM_DIGITS-1:0] i_dp;
  logic                  i_valid;
  logic                  o_ready;
  logic                  o_update;

  modport master (output i_value, i_dp, i_valid, input  o_ready, o_update);
  modport slave  (input  i_value, i_dp, i_valid, output o_ready, o_update);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq #(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [VALUE_W-1:0]      bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] sh_q;
  logic [BCD_W-1:0]   bcd_q, adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  // done marks the final shift; the result is stable from the next cycle on.
  assign done_o = busy_q && (cnt_q == CNT_W'(VALUE_W - 1));
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      sh_q   <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {adj[BCD_W-2:0], sh_q[VALUE_W-1]};
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/fnd_scan_controller.sv
// N-digit common-anode 7-segment scan driver: sequential BCD conversion, atomic
// shadow commit, leading-zero blanking, dp, overflow dashes and brightness PWM.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  fnd_scan_controller_if.slave  bus,
  input  logic                  i_blank_lz,
  input  logic [3:0]            i_bright,
  output logic [NUM_DIGITS-1:0] fnd_com,
  output logic [7:0]            fnd_data
);
  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int TCK_W    = $clog2(TICK_DIV);
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_W    = 4 * NUM_DIGITS;
  localparam logic [63:0] OVF_LIM = pow10(NUM_DIGITS) - 64'd1;

  logic [TCK_W-1:0]      tck_q;
  logic [IDX_W-1:0]      scan_q;
  logic [3:0]            pwm_q;
  logic                  tick;

  conv_state_e           state_q;
  logic                  ready_q, upd_q;
  logic [NUM_DIGITS-1:0] cap_dp_q;
  logic                  cap_ovf_q;
  logic [BCD_W-1:0]      shd_bcd_q;
  logic [NUM_DIGITS-1:0] shd_dp_q;
  logic                  shd_ovf_q;

  logic                  accept, cv_busy, cv_done;
  logic [BCD_W-1:0]      cv_bcd;

  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_above;
  logic [3:0]            nib;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] com_d, com_q;
  logic [7:0]            data_d, data_q;

  assign tick   = (tck_q == TCK_W'(TICK_DIV - 1));
  assign accept = (state_q == ST_IDLE) && bus.i_valid && ready_q;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (accept),
    .bin_i   (bus.i_value),
    .busy_o  (cv_busy),
    .done_o  (cv_done),
    .bcd_o   (cv_bcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tck_q  <= '0;
      scan_q <= '0;
      pwm_q  <= '0;
    end else begin
      tck_q <= tick ? '0 : tck_q + TCK_W'(1);
      pwm_q <= pwm_q + 4'd1;
      if (tick) scan_q <= (scan_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      upd_q     <= 1'b0;
      cap_dp_q  <= '0;
      cap_ovf_q <= 1'b0;
      shd_bcd_q <= '0;
      shd_dp_q  <= '0;
      shd_ovf_q <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          cap_dp_q  <= bus.i_dp;
          cap_ovf_q <= (64'(bus.i_value) > OVF_LIM);
          ready_q   <= 1'b0;
          state_q   <= ST_CONV;
        end
        ST_CONV: begin
          if (cv_done) state_q <= ST_COMMIT;
          else if (!cv_busy) begin
            // Converter lost its job; drop the value rather than wedge.
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          shd_bcd_q <= cv_bcd;
          shd_dp_q  <= cap_dp_q;
          shd_ovf_q <= cap_ovf_q;
          upd_q     <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A digit blanks when it and every digit above it are zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (shd_bcd_q[4*k +: 4] == 4'd0);
      blank[k]   = i_blank_lz && (k > 0) && zero_above;
    end
  end

  always_comb begin
    nib = shd_bcd_q[4*int'(scan_q) +: 4];
    if (shd_ovf_q)           seg = SEG_DASH;
    else if (blank[scan_q])  seg = SEG_BLANK;
    else                     seg = seg7_encode(nib);
    data_d = {~shd_dp_q[scan_q], seg};
    com_d  = '1;
    if (i_bright == 4'hF || pwm_q < i_bright) com_d[scan_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      com_q  <= '1;
      data_q <= 8'hFF;
    end else begin
      com_q  <= com_d;
      data_q <= data_d;
    end
  end

  assign fnd_com      = com_q;
  assign fnd_data     = data_q;
  assign bus.o_ready  = ready_q;
  assign bus.o_update = upd_q;
endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed + randomized bench for fnd_scan_controller against a decimal display model.
module tb_fnd_scan_controller;
  localparam int ND = 4;
  localparam int VW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          blank_lz = 1'b0;
  logic [3:0]    bright = 4'hF;
  logic [ND-1:0] fnd_com;
  logic [7:0]    fnd_data;

  fnd_scan_controller_if #(.NUM_DIGITS(ND), .VALUE_W(VW)) bus ();

  fnd_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(100), .NUM_DIGITS(ND), .VALUE_W(VW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .i_blank_lz (blank_lz),
    .i_bright   (bright),
    .fnd_com    (fnd_com),
    .fnd_data   (fnd_data)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the scan/PWM phase follows from it.
  int unsigned ncyc;
  always @(posedge clk or negedge reset)
    if (!reset) ncyc <= 0;
    else        ncyc <= ncyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int            m_val = 0;
  logic [ND-1:0] m_dp  = '0;
  logic [7:0]    tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  function automatic logic [7:0] exp_data(input int k);
    int         p;
    logic [7:0] t;
    logic [6:0] s;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    t = tbl[(m_val / p) % 10];
    if (m_val > 9999)                      s = 7'h3F;
    else if (blank_lz && k > 0 && m_val < p) s = 7'h7F;
    else                                   s = t[6:0];
    return {~m_dp[k], s};
  endfunction

  task automatic check_scan(input string tag, input int ncycles);
    int         n, idx, pwm;
    logic [3:0] ecom;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      n    = int'(ncyc);
      idx  = ((n - 1) / 10) % ND;
      pwm  = (n - 1) % 16;
      ecom = 4'hF;
      if (bright == 4'hF || pwm < int'(bright)) ecom[idx] = 1'b0;
      chk({tag, "_com"}, 32'(fnd_com), 32'(ecom));
      chk({tag, "_data"}, 32'(fnd_data), 32'(exp_data(idx)));
    end
  endtask

  // Called at a negedge while idle; returns at the negedge right after the commit edge.
  task automatic send(input int v, input logic [ND-1:0] dp);
    chk("rdy_idle", 32'(bus.o_ready), 32'd1);
    bus.i_value = VW'(v);
    bus.i_dp    = dp;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("rdy_conv", 32'(bus.o_ready), 32'd0);
      chk("upd_conv", 32'(bus.o_update), 32'd0);
      @(negedge clk);
    end
    chk("rdy_back", 32'(bus.o_ready), 32'd1);
    chk("upd_pulse", 32'(bus.o_update), 32'd1);
    m_val = v;
    m_dp  = dp;
  endtask

  initial begin
    bus.i_value = '0;
    bus.i_dp    = '0;
    bus.i_valid = 1'b0;

    // reset state
    #12;
    chk("rst_com", 32'(fnd_com), 32'hF);
    chk("rst_data", 32'(fnd_data), 32'hFF);
    chk("rst_rdy", 32'(bus.o_ready), 32'd1);
    chk("rst_upd", 32'(bus.o_update), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // idle scan of zero, blanking off then on
    check_scan("idle", 40);
    blank_lz = 1'b1;
    check_scan("idle_lz", 40);
    blank_lz = 1'b0;

    send(1234, 4'b0100);
    check_scan("v1234", 40);
    send(9999, 4'b0000);
    check_scan("v9999", 40);
    send(10000, 4'b0000);
    check_scan("ovf", 40);

    blank_lz = 1'b1;
    send(7, 4'b0000);
    check_scan("v7_lz", 40);
    blank_lz = 1'b0;
    check_scan("v7_nolz", 40);

    bright = 4'd4;
    check_scan("br4", 48);
    bright = 4'd0;
    check_scan("br0", 32);
    bright = 4'd15;
    check_scan("br15", 32);

    // back-to-back: second accept in the first idle cycle
    send(42, 4'b0001);
    send(305, 4'b1000);
    check_scan("b2b", 40);

    for (int r = 0; r < 12; r++) begin
      blank_lz = 1'($urandom_range(0, 1));
      bright   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      send(($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 16383))
                                       : int'($urandom_range(0, 9999)),
           4'($urandom_range(0, 15)));
      check_scan("rand", 40);
    end
    bright   = 4'hF;
    blank_lz = 1'b0;

    // hold valid through conversion, then reset mid-conversion
    bus.i_value = VW'(4321);
    bus.i_dp    = 4'b1111;
    bus.i_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      chk("hold_rdy", 32'(bus.o_ready), 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("mid_rst_com", 32'(fnd_com), 32'hF);
    chk("mid_rst_data", 32'(fnd_data), 32'hFF);
    chk("mid_rst_rdy", 32'(bus.o_ready), 32'd1);
    chk("mid_rst_upd", 32'(bus.o_update), 32'd0);
    bus.i_valid = 1'b0;
    m_val = 0;
    m_dp  = '0;
    @(negedge clk);
    reset = 1'b1;
    check_scan("post_rst", 40);
    chk("post_rst_upd", 32'(bus.o_update), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
